// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU-side target routing slice: target IDs and router state encoding.
package mcu_pkg;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_FORWARD = 2'd2,
    ST_DISCARD = 2'd3
  } router_state_t;

endpackage

// File: rtl/mcu_frame_timer.sv
// Frame stall timer: counts cycles while run is high, pulses expired combinationally when it hits TIMEOUT.
// No backpressure; clear has priority over expiry so a strobe on the last cycle keeps the frame alive.
module mcu_frame_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = run && !clear && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || expired || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mcu_target_router.sv
// Routes framed SPI bytes to a target chosen by the frame's first byte; forward and reply paths are 1-cycle registered.
// No backpressure: every strobe is consumed in its cycle, stalled frames are aborted by the frame timer.
module mcu_target_router
  import mcu_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_strobe,
  input  logic                     spi_start,
  input  logic [7:0]               spi_din,
  output logic [7:0]               spi_dout,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_din,
  input  logic [8*NUM_TARGETS-1:0] tgt_dout,
  input  logic [NUM_TARGETS-1:0]   tgt_int_n,
  output logic                     int_out_n,
  output logic [NUM_TARGETS-1:0]   int_src,
  output logic                     busy,
  output logic [7:0]               err_cnt
);

  localparam int SW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  router_state_t state, state_nxt;
  logic [SW-1:0] sel;

  logic start_stb, data_stb, id_ok, expired;
  logic fwd, fwd_first, err_inc;
  logic [7:0] reply, dout_nxt;
  logic [NUM_TARGETS-1:0] strobe_nxt;

  assign start_stb = spi_strobe && spi_start;
  assign data_stb  = spi_strobe && !spi_start;
  assign id_ok     = ({1'b0, spi_din} < 9'(NUM_TARGETS));

  mcu_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (spi_strobe),
    .run     (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start byte restarts framing from any state; the timer can only fire on strobe-free cycles.
  always_comb begin
    state_nxt = state;
    if (start_stb) begin
      state_nxt = id_ok ? ST_SELECT : ST_DISCARD;
    end else if (expired) begin
      state_nxt = ST_IDLE;
    end else if (data_stb && state == ST_SELECT) begin
      state_nxt = ST_FORWARD;
    end
  end

  always_comb begin
    fwd        = data_stb && (state == ST_SELECT || state == ST_FORWARD);
    fwd_first  = data_stb && (state == ST_SELECT);
    err_inc    = (start_stb && !id_ok) || expired;
    reply      = 8'h00;
    strobe_nxt = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel == SW'(i)) begin
        reply         = tgt_dout[8*i +: 8];
        strobe_nxt[i] = fwd;
      end
    end
    // The ID byte itself always answers 0x00, even when it opens a valid frame.
    dout_nxt = 8'h00;
    if (!start_stb && (state_nxt == ST_SELECT || state_nxt == ST_FORWARD)) begin
      dout_nxt = reply;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= '0;
      spi_dout   <= 8'h00;
      tgt_strobe <= '0;
      tgt_start  <= 1'b0;
      tgt_din    <= 8'h00;
      int_out_n  <= 1'b1;
      int_src    <= '0;
      err_cnt    <= 8'h00;
    end else begin
      if (start_stb && id_ok) begin
        sel <= spi_din[SW-1:0];
      end
      spi_dout   <= dout_nxt;
      tgt_strobe <= strobe_nxt;
      tgt_start  <= fwd_first;
      if (fwd) begin
        tgt_din <= spi_din;
      end
      int_out_n <= &tgt_int_n;
      int_src   <= ~tgt_int_n;
      if (err_inc && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mcu_target_router.sv
// Directed bench for mcu_target_router: forwarding, reply mux, unknown IDs, timeout, saturation, restart, reset, interrupts.
module tb_mcu_target_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_strobe, spi_start;
  logic [7:0]  spi_din, spi_dout;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_din;
  logic [31:0] tgt_dout;
  logic [3:0]  tgt_int_n;
  logic        int_out_n;
  logic [3:0]  int_src;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int scnt[4] = '{0, 0, 0, 0};
  int base[4];

  always #5 clk = ~clk;

  mcu_target_router #(.NUM_TARGETS(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_strobe (spi_strobe),
    .spi_start  (spi_start),
    .spi_din    (spi_din),
    .spi_dout   (spi_dout),
    .tgt_strobe (tgt_strobe),
    .tgt_start  (tgt_start),
    .tgt_din    (tgt_din),
    .tgt_dout   (tgt_dout),
    .tgt_int_n  (tgt_int_n),
    .int_out_n  (int_out_n),
    .int_src    (int_src),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // Per-target strobe counter, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) scnt[i] += int'(tgt_strobe[i]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents one byte for one cycle, returns at the following negedge.
  task automatic send(input logic start, input logic [7:0] din);
    spi_strobe = 1'b1;
    spi_start  = start;
    spi_din    = din;
    @(negedge clk);
    spi_strobe = 1'b0;
    spi_start  = 1'b0;
  endtask

  task automatic snap();
    #1;
    for (int i = 0; i < 4; i++) base[i] = scnt[i];
  endtask

  task automatic chk_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
    #1;
    chk({tag, "_t0"}, 32'(scnt[0] - base[0]), 32'(e0));
    chk({tag, "_t1"}, 32'(scnt[1] - base[1]), 32'(e1));
    chk({tag, "_t2"}, 32'(scnt[2] - base[2]), 32'(e2));
    chk({tag, "_t3"}, 32'(scnt[3] - base[3]), 32'(e3));
  endtask

  initial begin
    reset      = 1'b1;
    spi_strobe = 1'b0;
    spi_start  = 1'b0;
    spi_din    = 8'h00;
    tgt_dout   = {8'h33, 8'hA5, 8'h22, 8'h5C};
    tgt_int_n  = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_strobe", tgt_strobe, 0);
    chk("rst_start", tgt_start, 0);
    chk("rst_din", tgt_din, 0);
    chk("rst_dout", spi_dout, 0);
    chk("rst_intn", int_out_n, 1);
    chk("rst_isrc", int_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // Forwarding to target 0, back-to-back bytes.
    snap();
    @(negedge clk);
    send(1'b1, 8'h00);
    chk("fw_id_strobe", tgt_strobe, 0);
    chk("fw_id_dout", spi_dout, 8'h00);
    chk("fw_busy", busy, 1);
    send(1'b0, 8'h04);
    chk("fw_b1_strobe", tgt_strobe, 4'b0001);
    chk("fw_b1_start", tgt_start, 1);
    chk("fw_b1_din", tgt_din, 8'h04);
    chk("fw_b1_dout", spi_dout, 8'h5C);
    send(1'b0, 8'h57);
    chk("fw_b2_strobe", tgt_strobe, 4'b0001);
    chk("fw_b2_start", tgt_start, 0);
    chk("fw_b2_din", tgt_din, 8'h57);
    send(1'b0, 8'h01);
    chk("fw_b3_din", tgt_din, 8'h01);
    @(negedge clk);
    chk("fw_pulse_end", tgt_strobe, 0);
    chk("fw_din_hold", tgt_din, 8'h01);
    chk_counts("fw_cnt", 3, 0, 0, 0);

    // Reply mux on target 2.
    @(negedge clk);
    send(1'b1, 8'h02);
    chk("mux_id_dout", spi_dout, 8'h00);
    send(1'b0, 8'h11);
    chk("mux_strobe", tgt_strobe, 4'b0100);
    chk("mux_dout", spi_dout, 8'hA5);
    tgt_dout[23:16] = 8'h3C;
    @(negedge clk);
    chk("mux_track", spi_dout, 8'h3C);

    // Unknown ID is discarded and counted; next frame routes normally.
    snap();
    @(negedge clk);
    send(1'b1, 8'h07);
    chk("unk_err", err_cnt, 1);
    chk("unk_busy", busy, 1);
    send(1'b0, 8'h99);
    chk("unk_dout", spi_dout, 8'h00);
    chk_counts("unk_cnt", 0, 0, 0, 0);
    @(negedge clk);
    send(1'b1, 8'h01);
    send(1'b0, 8'h42);
    chk("unk_next_strobe", tgt_strobe, 4'b0010);
    chk("unk_next_start", tgt_start, 1);
    chk("unk_next_din", tgt_din, 8'h42);

    // Stall timeout: 16 counted cycles after the start byte, then IDLE.
    send(1'b1, 8'h01);
    repeat (16) @(negedge clk);
    chk("to_busy_before", busy, 1);
    @(negedge clk);
    chk("to_busy_after", busy, 0);
    chk("to_err", err_cnt, 2);

    // A strobe on the expiry cycle wins over the timeout.
    send(1'b1, 8'h01);
    repeat (16) @(negedge clk);
    send(1'b0, 8'h10);
    chk("to_save_busy", busy, 1);
    chk("to_save_strobe", tgt_strobe, 4'b0010);
    chk("to_save_err", err_cnt, 2);
    repeat (16) @(negedge clk);
    chk("to2_busy_before", busy, 1);
    @(negedge clk);
    chk("to2_busy_after", busy, 0);
    chk("to2_err", err_cnt, 3);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 8'hFF);
      if (i == 99) chk("sat_mid", err_cnt, 8'h67);
    end
    chk("sat_final", err_cnt, 8'hFF);

    // Restart mid-FORWARD retargets the next payload.
    send(1'b1, 8'h00);
    send(1'b0, 8'hAA);
    chk("rs_first", tgt_strobe, 4'b0001);
    send(1'b1, 8'h03);
    chk("rs_id_strobe", tgt_strobe, 0);
    chk("rs_id_dout", spi_dout, 8'h00);
    send(1'b0, 8'hBB);
    chk("rs_strobe", tgt_strobe, 4'b1000);
    chk("rs_start", tgt_start, 1);
    chk("rs_din", tgt_din, 8'hBB);
    chk("rs_dout", spi_dout, 8'h33);

    // Reset mid-frame, coincident with a payload strobe.
    send(1'b1, 8'h02);
    snap();
    spi_strobe = 1'b1;
    spi_din    = 8'h77;
    reset      = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_din", tgt_din, 0);
    chk("mr_err", err_cnt, 0);
    chk("mr_intn", int_out_n, 1);
    @(negedge clk);
    spi_strobe = 1'b0;
    chk("mr_strobe", tgt_strobe, 0);
    chk("mr_start", tgt_start, 0);
    chk("mr_dout", spi_dout, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy_after", busy, 0);
    chk_counts("mr_cnt", 0, 0, 0, 0);

    // Interrupt aggregation.
    @(negedge clk);
    tgt_int_n = 4'b1011;
    #1;
    chk("int_latency", int_out_n, 1);
    @(negedge clk);
    chk("int_out", int_out_n, 0);
    chk("int_src", int_src, 4'b0100);
    tgt_int_n = 4'hF;
    @(negedge clk);
    chk("int_release", int_out_n, 1);
    chk("int_src_clr", int_src, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
